// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the pmem_arbiter slice: FSM state, cache-line type and
// the index-width helper used by the arbiter and its picker.
package pmem_arbiter_pkg;

   localparam int LINE_WIDTH_DEFAULT = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } pmem_arb_state_t;

   typedef logic [LINE_WIDTH_DEFAULT-1:0] cache_line_t;

   // Width of a port index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pmem_arbiter_rr_picker.sv
// Combinational requester picker: round-robin from rr_ptr, or fixed lowest-index
// priority when PMEM_ARB_FIXED_PRIORITY_EN is defined (then rr_ptr does not exist).
module pmem_arbiter_rr_picker
   import pmem_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = idx_width(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
`ifndef PMEM_ARB_FIXED_PRIORITY_EN
   input  logic [IDX_W-1:0]     rr_ptr,
`endif
   output logic [NUM_PORTS-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 valid
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
`ifndef PMEM_ARB_FIXED_PRIORITY_EN
      // First pass covers rr_ptr..NUM_PORTS-1; the second pass supplies the wrap.
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!valid && req[i] && (IDX_W'(i) >= rr_ptr)) begin
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
            valid     = 1'b1;
         end
      end
`endif
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!valid && req[i]) begin
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates NUM_PORTS cache-line requesters onto one pmem port, one transaction
// at a time. Define PMEM_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority.
module pmem_arbiter
   import pmem_arbiter_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0]             req_read,
   input  logic [NUM_PORTS-1:0]             req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]             req_resp,
   output logic [LINE_WIDTH-1:0]            req_rdata,
   output logic                             pmem_read,
   output logic                             pmem_write,
   output logic [ADDR_WIDTH-1:0]            pmem_address,
   output logic [LINE_WIDTH-1:0]            pmem_wdata,
   input  logic                             pmem_resp,
   input  logic [LINE_WIDTH-1:0]            pmem_rdata
);

   localparam int IDX_W = idx_width(NUM_PORTS);

   // Handshake: a port raises req_read or req_write and holds it until its
   // one-cycle req_resp pulse; pmem strobes stay high until the one-cycle pmem_resp.
   pmem_arb_state_t        state, state_next;
   logic [NUM_PORTS-1:0]   pick_grant;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;
   logic [ADDR_WIDTH-1:0]  lat_addr;
   logic [LINE_WIDTH-1:0]  lat_wdata;
   logic                   lat_write;
   logic [IDX_W-1:0]       lat_idx;
   logic [LINE_WIDTH-1:0]  rdata_q;

`ifndef PMEM_ARB_FIXED_PRIORITY_EN
   logic [IDX_W-1:0]       rr_ptr;
`endif

   pmem_arbiter_rr_picker #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_picker (
      .req       (req_read | req_write),
`ifndef PMEM_ARB_FIXED_PRIORITY_EN
      .rr_ptr    (rr_ptr),
`endif
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .valid     (pick_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pick_valid) state_next = BUSY;
         BUSY:    if (pmem_resp)  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      req_resp   = '0;
      case (state)
         BUSY: begin
            pmem_read  = !lat_write;
            pmem_write = lat_write;
         end
         RESP:    req_resp[lat_idx] = 1'b1;
         default: ;
      endcase
   end

   // Write wins when a port illegally raises both strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_write <= 1'b0;
         lat_idx   <= '0;
         rdata_q   <= '0;
      end else begin
         if (state == IDLE && pick_valid) begin
            lat_addr  <= req_address[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wdata <= req_wdata[pick_idx*LINE_WIDTH +: LINE_WIDTH];
            lat_write <= |(pick_grant & req_write);
            lat_idx   <= pick_idx;
         end
         if (state == BUSY && pmem_resp && !lat_write) rdata_q <= pmem_rdata;
      end
   end

`ifndef PMEM_ARB_FIXED_PRIORITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (state == IDLE && pick_valid) begin
         rr_ptr <= (pick_idx == IDX_W'(NUM_PORTS-1)) ? '0 : pick_idx + 1'b1;
      end
   end
`endif

   assign pmem_address = lat_addr;
   assign pmem_wdata   = lat_wdata;
   assign req_rdata    = rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a 2-port and a 4-port instance sharing clock,
// reset and the memory response; honours PMEM_ARB_FIXED_PRIORITY_EN.
module tb_pmem_arbiter;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]    req_read, req_write, req_resp;
   logic [63:0]   req_address;
   logic [511:0]  req_wdata;
   logic [255:0]  req_rdata, pmem_wdata, pmem_rdata;
   logic          pmem_read, pmem_write, pmem_resp;
   logic [31:0]   pmem_address;

   logic [3:0]    q_read, q_write, q_resp;
   logic [127:0]  q_address;
   logic [1023:0] q_wdata;
   logic [255:0]  q_rdata, q_pmem_wdata;
   logic          q_pmem_read, q_pmem_write;
   logic [31:0]   q_pmem_address;

   pmem_arbiter #(.NUM_PORTS(2), .LINE_WIDTH(256), .ADDR_WIDTH(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_read(req_read), .req_write(req_write), .req_address(req_address),
      .req_wdata(req_wdata), .req_resp(req_resp), .req_rdata(req_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   pmem_arbiter #(.NUM_PORTS(4), .LINE_WIDTH(256), .ADDR_WIDTH(32)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .req_read(q_read), .req_write(q_write), .req_address(q_address),
      .req_wdata(q_wdata), .req_resp(q_resp), .req_rdata(q_rdata),
      .pmem_read(q_pmem_read), .pmem_write(q_pmem_write), .pmem_address(q_pmem_address),
      .pmem_wdata(q_pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   // scoreboard
   int checks   = 0;
   int failures = 0;
   logic [1:0] exp_q[$];

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the first BUSY cycle; returns in the RESP cycle.
   task automatic serve(input int lat, input logic [255:0] data);
      for (int j = 1; j < lat; j++) tick();
      pmem_resp  = 1'b1;
      pmem_rdata = data;
      tick();
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
   endtask

   logic [255:0] line_a5, line_5a, line_beef, line_c3, line_k;
   logic [1:0]   exp_g;
   logic [31:0]  exp_addr;

   initial begin
      line_a5   = {32{8'hA5}};
      line_5a   = {32{8'h5A}};
      line_beef = {8{32'hDEADBEEF}};
      line_c3   = {32{8'hC3}};
      req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
      q_read = '0; q_write = '0; q_address = '0; q_wdata = '0;
      pmem_resp = 1'b0; pmem_rdata = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_req_resp", 256'(req_resp), 256'(0));
      check("reset_req_rdata", req_rdata, '0);
      check("reset_pmem_read", 256'(pmem_read), 256'(0));
      check("reset_pmem_write", 256'(pmem_write), 256'(0));
      check("reset_pmem_address", 256'(pmem_address), 256'(0));
      check("reset_pmem_wdata", pmem_wdata, '0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // single read from port 1, memory answers in the 5th BUSY cycle
      req_address[63:32] = 32'h0000_1000;
      req_read = 2'b10;
      check("rd_c0_idle", 256'(pmem_read), 256'(0));
      tick();
      check("rd_addr", 256'(pmem_address), 256'(32'h0000_1000));
      for (int c = 1; c <= 4; c++) begin
         check($sformatf("rd_strobe_c%0d", c), 256'(pmem_read), 256'(1));
         tick();
      end
      check("rd_strobe_c5", 256'(pmem_read), 256'(1));
      pmem_resp = 1'b1; pmem_rdata = line_a5;
      tick();
      pmem_resp = 1'b0; pmem_rdata = '0;
      check("rd_c6_resp", 256'(req_resp), 256'(2'b10));
      check("rd_c6_rdata", req_rdata, line_a5);
      check("rd_c6_strobe_low", 256'(pmem_read), 256'(0));
      req_read = '0;
      tick();
      check("rd_c7_resp_low", 256'(req_resp), 256'(0));
      check("rd_c7_rdata_held", req_rdata, line_a5);

      // stray pmem_resp while idle is ignored
      pmem_resp = 1'b1; pmem_rdata = line_5a;
      tick();
      pmem_resp = 1'b0; pmem_rdata = '0;
      check("stray_rdata_held", req_rdata, line_a5);
      check("stray_no_resp", 256'(req_resp), 256'(0));
      check("stray_idle", 256'(pmem_read | pmem_write), 256'(0));

      // write from port 0; req_rdata must not move
      req_address[31:0] = 32'h0000_2040;
      req_wdata[255:0]  = line_beef;
      req_write = 2'b01;
      tick();
      for (int c = 0; c < 3; c++) begin
         check("wr_strobe", 256'(pmem_write), 256'(1));
         check("wr_no_read", 256'(pmem_read), 256'(0));
         check("wr_addr", 256'(pmem_address), 256'(32'h0000_2040));
         check("wr_wdata", pmem_wdata, line_beef);
         if (c == 2) begin
            pmem_resp = 1'b1; pmem_rdata = line_5a;
         end
         tick();
      end
      pmem_resp = 1'b0; pmem_rdata = '0;
      check("wr_resp", 256'(req_resp), 256'(2'b01));
      check("wr_rdata_unchanged", req_rdata, line_a5);
      check("wr_strobe_low", 256'(pmem_write), 256'(0));
      req_write = '0;
      tick();
      check("wr_resp_one_cycle", 256'(req_resp), 256'(0));

      // port 0 drops its request one cycle after grant
      req_address[31:0] = 32'h0000_3000;
      req_read = 2'b01;
      tick();
      check("drop_c1_strobe", 256'(pmem_read), 256'(1));
      req_read = '0;
      tick();
      check("drop_c2_strobe", 256'(pmem_read), 256'(1));
      check("drop_c2_addr", 256'(pmem_address), 256'(32'h0000_3000));
      serve(2, line_c3);
      check("drop_resp", 256'(req_resp), 256'(2'b01));
      check("drop_rdata", req_rdata, line_c3);
      tick();
      check("drop_resp_low", 256'(req_resp), 256'(0));
      check("drop_no_regrant", 256'(pmem_read), 256'(0));

      // async reset in BUSY, between clock edges
      req_address[31:0] = 32'h0000_4000;
      req_read = 2'b01;
      tick();
      check("rst_busy_strobe", 256'(pmem_read), 256'(1));
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_strobe", 256'(pmem_read), 256'(0));
      check("rst_async_resp", 256'(req_resp), 256'(0));
      check("rst_async_rdata", req_rdata, '0);
      check("rst_async_addr", 256'(pmem_address), 256'(0));
      req_read = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // both ports request continuously from reset
`ifdef PMEM_ARB_FIXED_PRIORITY_EN
      exp_q = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      req_address[31:0]  = 32'h0000_5000;
      req_address[63:32] = 32'h0000_6000;
      req_read = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_g    = exp_q.pop_front();
         exp_addr = (exp_g == 2'b01) ? 32'h0000_5000 : 32'h0000_6000;
         line_k   = {8{32'h1111_0000 + 32'(k)}};
         tick();
         check($sformatf("alt%0d_strobe", k), 256'(pmem_read), 256'(1));
         check($sformatf("alt%0d_addr", k), 256'(pmem_address), 256'(exp_addr));
         serve(2, line_k);
         check($sformatf("alt%0d_grant", k), 256'(req_resp), 256'(exp_g));
         check($sformatf("alt%0d_rdata", k), req_rdata, line_k);
         tick();
      end
      req_read = '0;
      tick();
      check("alt_done_idle", 256'(pmem_read), 256'(0));

      // 4-port wrap: grant port 2 first so rr_ptr becomes 3
      for (int i = 0; i < 4; i++) q_address[i*32 +: 32] = 32'h100 * 32'(i + 1);
      q_read = 4'b0100;
      tick();
      check("p4_first_addr", 256'(q_pmem_address), 256'(32'h300));
      check("p4_first_strobe", 256'(q_pmem_read), 256'(1));
      serve(2, line_5a);
      check("p4_first_resp", 256'(q_resp), 256'(4'b0100));
      check("p4_first_rdata", q_rdata, line_5a);
      check("p2_untouched", 256'(req_resp), 256'(0));
      q_read = 4'b0101;
      tick();
      tick();
      check("p4_wrap_addr", 256'(q_pmem_address), 256'(32'h100));
      serve(3, line_a5);
      check("p4_wrap_resp", 256'(q_resp), 256'(4'b0001));
      q_read = 4'b0100;
      tick();
      tick();
      check("p4_next_addr", 256'(q_pmem_address), 256'(32'h300));
      serve(2, line_c3);
      check("p4_next_resp", 256'(q_resp), 256'(4'b0100));
      check("p4_next_rdata", q_rdata, line_c3);
      q_read = '0;
      tick();
      check("p4_idle_resp", 256'(q_resp), 256'(0));

      // report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Parametrised successor to the single-cache memory path: arbitrates NUM_PORTS cache-line requesters onto one physical memory port.
- Typical requesters: split I-cache and D-cache, later an L2 or prefetcher.
- Sits between the caches and pmem.
- Round-robin grant, one outstanding transaction, registered response data broadcast to all ports.

Parameters:
- NUM_PORTS, 2, number of requesting caches (>=2)
- LINE_WIDTH, 256, cache line width in bits
- ADDR_WIDTH, 32, physical address width

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_read  input  NUM_PORTS  per-port line read request, held until that port's req_resp
- req_write  input  NUM_PORTS  per-port line write request, held until req_resp
- req_address  input  NUM_PORTS*ADDR_WIDTH  per-port line address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  NUM_PORTS*LINE_WIDTH  per-port write line, packed the same way
- req_resp  output  NUM_PORTS  one-hot, one-cycle completion pulse to the granted port
- req_rdata  output  LINE_WIDTH  registered read line, valid when the matching req_resp is high
- pmem_read  output  1  memory read strobe
- pmem_write  output  1  memory write strobe
- pmem_address  output  ADDR_WIDTH  memory line address
- pmem_wdata  output  LINE_WIDTH  memory write line
- pmem_resp  input  1  memory completion, one cycle
- pmem_rdata  input  LINE_WIDTH  memory read line, valid with pmem_resp

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: all outputs 0.
  - Internal state: state=IDLE, rr_ptr=0, latched address/wdata/op/grant cleared.
- Reset asserted mid-transaction abandons it. No req_resp is issued; requesters must also be reset.
- States:
  - IDLE
    - Any port with req_read|req_write pending → select winner, latch its address, wdata, op and index, set rr_ptr=(winner+1) mod NUM_PORTS, go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY
    - pmem_read or pmem_write is driven from the latched op and held steady.
    - pmem_address and pmem_wdata are driven from latched values.
    - On pmem_resp: capture pmem_rdata into the req_rdata register, go to RESP.
  - RESP
    - req_resp[grant]=1 for exactly this cycle; pmem strobes are 0.
    - Unconditionally return to IDLE.
- Arbitration (round-robin): search ports starting at rr_ptr, increasing index, wrapping at NUM_PORTS-1→0. The first requesting port wins.
- Latency:
  - Request visible in IDLE at cycle 0 → pmem strobe high in cycle 1.
  - pmem_resp in cycle k → req_resp and req_rdata in cycle k+1.
  - Next grant earliest in cycle k+2.
  - Minimum turnaround is 3 cycles plus memory latency.
- Request changes after grant (drop, address change) are ignored. The latched transaction completes and req_resp is still pulsed.
- req_read and req_write both high on one port is illegal; the arbiter performs the write only.
- req_rdata holds its last value until the next pmem_resp. After a write, req_rdata is not updated.
- pmem_resp outside BUSY is ignored.
- Ungranted requests wait indefinitely.
- Round-robin guarantees each pending port a grant within NUM_PORTS transactions.

Optional Feature:
- Macro: PMEM_ARB_FIXED_PRIORITY_EN.
- Defined:
  - Fixed priority: lowest index wins; port 0 (I-cache) is always favoured.
  - rr_ptr is not instantiated.
  - Starvation of higher ports is permitted.
- Undefined: round-robin as above.

Decomposition:
- rv32i_types gains:
  - pmem_arb_state_t enum {IDLE, BUSY, RESP}
  - a cache-line typedef sized by LINE_WIDTH default 256
- Sub-module rr_picker: combinational; request vector and rr_ptr in; one-hot grant, grant index and valid out.
  - Parametrised by NUM_PORTS.
  - Holds both the round-robin and fixed-priority variants.

Test Plan:
- Single read: port 1 reads 0x0000_1000; memory returns line 0xA5..A5 after 4 cycles → pmem_read high cycles 1-5; req_resp=2'b10 in cycle 6 with req_rdata=0xA5..A5; pmem_read 0 in cycle 6.
- Simultaneous requests, NUM_PORTS=2, both continuously requesting from reset → grants alternate 0,1,0,1. Under PMEM_ARB_FIXED_PRIORITY_EN, port 0 is granted every time while it keeps re-requesting.
- Write: port 0 writes 0x0000_2040 with wdata 0xDEAD..BEEF → pmem_write, pmem_address and pmem_wdata stable until pmem_resp; req_rdata unchanged; req_resp=2'b01 for one cycle.
- Mid-transaction request drop: port 0 deasserts req_read one cycle after grant → pmem_read stays high until pmem_resp; req_resp[0] still pulses.
- Async reset in BUSY: rst_n low between clock edges → pmem_read, req_resp and req_rdata 0 immediately; after release, the first request grants from port 0.
- NUM_PORTS=4 wrap: rr_ptr=3 with ports 0 and 2 requesting → port 0 granted, then port 2.
